datapath_ctrl: RTL and testbench

- Multi-cycle controller that sequences the 16-bit datapath around the ALU and its 8-entry register file.
- Latches one instruction per start handshake.
- Walks a Moore FSM that drives register-file read/write, A/B/C/status load enables, operand selects, shift code and ALU op, then returns to idle.
- Sits between the instruction source (test harness now, fetch unit later) and the datapath.

---
 rtl/datapath_ctrl_pkg.sv | 67 ++++++
 rtl/datapath_ctrl_instr_dec.sv | 17 +
 rtl/datapath_ctrl.sv | 151 +++++++++++++++
 tb/tb_datapath_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared constants, state encoding and payload types for the datapath controller.
package datapath_ctrl_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 3;

    // ALU operation codes, identical to the ALU's own encoding
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    // Major opcodes and MOV sub-opcodes
    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;

    // Writeback source select
    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b01;

    typedef enum logic [2:0] {
        S_WAIT = 3'd0,
        S_DEC  = 3'd1,
        S_GETA = 3'd2,
        S_GETB = 3'd3,
        S_ALU  = 3'd4,
        S_WRC  = 3'd5,
        S_WRI  = 3'd6
    } state_t;

    // Instruction word split into its fields (MSB first)
    typedef struct packed {
        logic [2:0]        opc;
        logic [1:0]        op;
        logic [REG_AW-1:0] rn;
        logic [REG_AW-1:0] rd;
        logic [1:0]        sh;
        logic [REG_AW-1:0] rm;
    } instr_t;

    // Registered control word driven to the datapath
    typedef struct packed {
        logic              ready;
        logic              err;
        logic [REG_AW-1:0] readnum;
        logic [REG_AW-1:0] writenum;
        logic              write;
        logic              loada;
        logic              loadb;
        logic              loadc;
        logic              loads;
        logic              asel;
        logic              bsel;
        logic [1:0]        vsel;
        logic [1:0]        shift;
        logic [1:0]        aluop;
    } ctrl_t;

    // True for the six instructions the controller knows how to sequence
    function automatic logic instr_legal(input instr_t f);
        return (f.opc == OPC_ALU) ||
               ((f.opc == OPC_MOV) && ((f.op == OP_MOV_IMM) || (f.op == OP_MOV_REG)));
    endfunction

endpackage

// File: rtl/datapath_ctrl_instr_dec.sv
// Field extraction, legality and immediate sign extension for the held instruction.
module datapath_ctrl_instr_dec
    import datapath_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] ir,
    output instr_t            fields_c,
    output logic              legal_c,
    output logic [DATA_W-1:0] sximm8_c,
    output logic [DATA_W-1:0] sximm5_c
);

    assign fields_c = instr_t'(ir);
    assign legal_c  = instr_legal(instr_t'(ir));
    assign sximm8_c = {{(DATA_W - 8){ir[7]}}, ir[7:0]};
    assign sximm5_c = {{(DATA_W - 5){ir[4]}}, ir[4:0]};

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle Moore controller sequencing register file, A/B/C/status loads and ALU.
module datapath_ctrl
    import datapath_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] instr,
    output logic              ready,
    output logic              err,
    output logic [REG_AW-1:0] readnum,
    output logic [REG_AW-1:0] writenum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        vsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic [DATA_W-1:0] sximm8,
    output logic [DATA_W-1:0] sximm5
);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] ir_nxt;
    instr_t            f;
    logic              legal;
    logic              is_cmp;
    ctrl_t             ctrl_q;
    ctrl_t             ctrl_nxt;

    datapath_ctrl_instr_dec u_instr_dec (
        .ir       (ir),
        .fields_c (f),
        .legal_c  (legal),
        .sximm8_c (sximm8),
        .sximm5_c (sximm5)
    );

    assign is_cmp = (f.opc == OPC_ALU) && (f.op == ALU_SUB);

    // Next state and instruction capture; start is only honoured while waiting
    always_comb begin
        state_nxt = state;
        ir_nxt    = ir;
        unique case (state)
            S_WAIT: begin
                if (start) begin
                    ir_nxt    = instr;
                    state_nxt = S_DEC;
                end
            end
            S_DEC: begin
                if (!legal) begin
                    state_nxt = S_WAIT;
                end else if (f.opc == OPC_MOV) begin
                    state_nxt = (f.op == OP_MOV_IMM) ? S_WRI : S_GETB;
                end else if (f.op == ALU_NOT) begin
                    state_nxt = S_GETB;
                end else begin
                    state_nxt = S_GETA;
                end
            end
            S_GETA:  state_nxt = S_GETB;
            S_GETB:  state_nxt = S_ALU;
            S_ALU:   state_nxt = is_cmp ? S_WAIT : S_WRC;
            S_WRC:   state_nxt = S_WAIT;
            S_WRI:   state_nxt = S_WAIT;
            default: state_nxt = S_WAIT;
        endcase
    end

    // Control word for the state being entered, so every output comes straight
    // from a flop. The held IR fields are valid for every state past S_DEC; on
    // entry to S_DEC the word is fresh, so err is judged on the captured value.
    always_comb begin
        ctrl_nxt = '0;
        unique case (state_nxt)
            S_WAIT: ctrl_nxt.ready = 1'b1;
            S_DEC:  ctrl_nxt.err   = !instr_legal(instr_t'(ir_nxt));
            S_GETA: begin
                ctrl_nxt.readnum = f.rn;
                ctrl_nxt.loada   = 1'b1;
            end
            S_GETB: begin
                ctrl_nxt.readnum = f.rm;
                ctrl_nxt.loadb   = 1'b1;
            end
            S_ALU: begin
                ctrl_nxt.shift = f.sh;
                if (f.opc == OPC_MOV) begin
                    ctrl_nxt.aluop = ALU_ADD;
                    ctrl_nxt.asel  = 1'b1;
                end else begin
                    ctrl_nxt.aluop = f.op;
                end
                if (is_cmp) begin
                    ctrl_nxt.loads = 1'b1;
                end else begin
                    ctrl_nxt.loadc = 1'b1;
                end
            end
            S_WRC: begin
                ctrl_nxt.vsel     = VSEL_C;
                ctrl_nxt.writenum = f.rd;
                ctrl_nxt.write    = 1'b1;
            end
            S_WRI: begin
                ctrl_nxt.vsel     = VSEL_IMM;
                ctrl_nxt.writenum = f.rn;
                ctrl_nxt.write    = 1'b1;
            end
            default: ctrl_nxt = '0;
        endcase
    end

    // State, instruction register and control word; reset aborts any pending write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_WAIT;
            ir           <= '0;
            ctrl_q       <= '0;
            ctrl_q.ready <= 1'b1;
        end else begin
            state  <= state_nxt;
            ir     <= ir_nxt;
            ctrl_q <= ctrl_nxt;
        end
    end

    assign ready    = ctrl_q.ready;
    assign err      = ctrl_q.err;
    assign readnum  = ctrl_q.readnum;
    assign writenum = ctrl_q.writenum;
    assign write    = ctrl_q.write;
    assign loada    = ctrl_q.loada;
    assign loadb    = ctrl_q.loadb;
    assign loadc    = ctrl_q.loadc;
    assign loads    = ctrl_q.loads;
    assign asel     = ctrl_q.asel;
    assign bsel     = ctrl_q.bsel;
    assign vsel     = ctrl_q.vsel;
    assign shift    = ctrl_q.shift;
    assign ALUop    = ctrl_q.aluop;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Self-checking bench for datapath_ctrl: per-instruction step lists plus directed literals.
module tb_datapath_ctrl;

    typedef struct packed {
        logic       ready;
        logic       err;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic [1:0] shift;
        logic [1:0] aluop;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] instr;
    logic        ready, err, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, ALUop;
    logic [15:0] sximm8, sximm5;

    int   total;
    int   bad;
    logic chk_en;

    exp_t        q[$];
    logic [15:0] m_ir;

    datapath_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .instr    (instr),
        .ready    (ready),
        .err      (err),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm8   (sximm8),
        .sximm5   (sximm5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output lists, one entry per busy cycle after the accept edge; an empty list means idle.
    task automatic build(input logic [15:0] i);
        logic [2:0] opc;
        logic [1:0] op;
        logic       mov_imm, mov_reg, alu, cmp;
        exp_t       e;
        opc     = i[15:13];
        op      = i[12:11];
        mov_imm = (opc == 3'b110) && (op == 2'b10);
        mov_reg = (opc == 3'b110) && (op == 2'b00);
        alu     = (opc == 3'b101);
        cmp     = alu && (op == 2'b01);
        e = '0;
        e.err = !(mov_imm || mov_reg || alu);
        q.push_back(e);
        if (mov_imm) begin
            e = '0; e.write = 1'b1; e.writenum = i[10:8]; e.vsel = 2'b01;
            q.push_back(e);
        end else if (mov_reg || alu) begin
            if (alu && op != 2'b11) begin
                e = '0; e.loada = 1'b1; e.readnum = i[10:8];
                q.push_back(e);
            end
            e = '0; e.loadb = 1'b1; e.readnum = i[2:0];
            q.push_back(e);
            e = '0; e.shift = i[4:3];
            e.aluop = mov_reg ? 2'b00 : op;
            e.asel  = mov_reg;
            if (cmp) e.loads = 1'b1; else e.loadc = 1'b1;
            q.push_back(e);
            if (!cmp) begin
                e = '0; e.write = 1'b1; e.writenum = i[7:5]; e.vsel = 2'b00;
                q.push_back(e);
            end
        end
    endtask

    // Reference model: accept when idle, otherwise consume one step per clock
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_ir = 16'h0000;
        end else if (q.size() == 0) begin
            if (start) begin
                m_ir = instr;
                build(instr);
            end
        end else begin
            void'(q.pop_front());
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        exp_t        want;
        exp_t        got;
        logic [31:0] sx_want;
        if (chk_en) begin
            want = '0;
            want.ready = 1'b1;
            if (q.size() != 0) want = q[0];
            got = {ready, err, readnum, writenum, write, loada, loadb, loadc,
                   loads, asel, bsel, vsel, shift, ALUop};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL ctl t=%0t got=%h want=%h", $time, got, want);
            end
            sx_want = {{{8{m_ir[7]}}, m_ir[7:0]}, {{11{m_ir[4]}}, m_ir[4:0]}};
            total++;
            if ({sximm8, sximm5} !== sx_want) begin
                bad++;
                $display("FAIL sximm t=%0t got=%h want=%h", $time, {sximm8, sximm5}, sx_want);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction and let the accept edge pass; leaves the DUT in S_DEC
    task automatic issue(input logic [15:0] i);
        start = 1'b1;
        instr = i;
        cyc();
        start = 1'b0;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 3))
            0: ;
            1: r[15:11] = {3'b110, ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00};
            default: r[15:13] = 3'b101;
        endcase
        return r;
    endfunction

    initial begin
        total   = 0;
        bad     = 0;
        chk_en  = 1'b0;
        reset_n = 1'b1;
        start   = 1'b0;
        instr   = 16'h0000;
        #2 reset_n = 1'b0;
        chk_en = 1'b1;
        cyc();
        chk("rst_ready", 16'(ready), 16'h1);
        chk("rst_ctl", {6'b0, err, write, loada, loadb, loadc, loads, vsel, ALUop}, 16'h0);
        chk("rst_sximm8", sximm8, 16'h0000);
        cyc();
        reset_n = 1'b1;
        cyc();

        // MOV R3, #-2
        issue(16'hD3FE);
        chk("movi_dec_en", {11'b0, write, loada, loadb, loadc, loads}, 16'h0);
        chk("movi_dec_ready", 16'(ready), 16'h0);
        cyc();
        chk("movi_write", 16'(write), 16'h1);
        chk("movi_writenum", 16'(writenum), 16'h3);
        chk("movi_vsel", 16'(vsel), 16'h1);
        chk("movi_sximm8", sximm8, 16'hFFFE);
        cyc();
        chk("movi_ready", 16'(ready), 16'h1);

        // ADD R2, R1, R0 LSL1
        issue(16'hA148);
        cyc();
        chk("add_geta", {12'b0, loada, readnum}, 16'h0009);
        cyc();
        chk("add_getb", {12'b0, loadb, readnum}, 16'h0008);
        cyc();
        chk("add_alu", {11'b0, loadc, shift, ALUop}, 16'h0014);
        cyc();
        chk("add_wrc", {11'b0, ready, write, writenum}, 16'h000A);
        cyc();
        chk("add_ready5", 16'(ready), 16'h1);

        // CMP R1, R0
        issue(16'hA900);
        cyc();
        cyc();
        cyc();
        chk("cmp_alu", {11'b0, loads, loadc, write, ALUop}, 16'h0011);
        cyc();
        chk("cmp_ready4", 16'(ready), 16'h1);

        // Illegal opcode
        issue(16'hE000);
        chk("ill_err", {11'b0, err, ready, write, loada, loadb}, 16'h0010);
        cyc();
        chk("ill_done", {14'b0, err, ready}, 16'h0001);

        // Back-to-back: MVN R7, R1 LSL1 then MOV R5, #5 with start held high
        start = 1'b1;
        instr = 16'hB8E9;
        cyc();
        instr = 16'hE000;
        cyc();
        chk("b2b_ir_held", sximm8, 16'hFFE9);
        cyc();
        chk("b2b_mvn_alu", {11'b0, loadc, shift, ALUop}, 16'h0017);
        cyc();
        chk("b2b_mvn_wrc", {12'b0, write, writenum}, 16'h000F);
        instr = 16'hD505;
        cyc();
        chk("b2b_ready", 16'(ready), 16'h1);
        cyc();
        start = 1'b0;
        chk("b2b_second_dec", {14'b0, ready, err}, 16'h0000);
        cyc();
        chk("b2b_movi", {12'b0, write, writenum}, 16'h000D);
        chk("b2b_sximm8", sximm8, 16'h0005);
        cyc();

        // Reset in the middle of an ADD's B fetch
        issue(16'hA148);
        cyc();
        cyc();
        chk("rst_mid_loadb", 16'(loadb), 16'h1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid", {13'b0, ready, write, loadb}, 16'h0004);
        cyc();
        cyc();
        chk("rst_mid_nowrite", 16'(write), 16'h0);
        reset_n = 1'b1;
        cyc();

        // Randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 2) != 0);
            instr = rand_instr();
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0;
                cyc();
                reset_n = 1'b1;
            end
            cyc();
        end

        start = 1'b0;
        repeat (8) cyc();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
